// File: rtl/reg_mux_n.sv
// Registered N-channel multiplexer with direct-select and round-robin scan modes.
// All outputs update one clk edge after the sampled inputs; xfer_cnt counts transfers.
module reg_mux_n #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic                 hold,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_ch,
  output logic [15:0]          xfer_cnt
);

  localparam logic [SELW:0]     NCH_W = NCH[SELW:0];
  localparam logic [SELW-1:0]   LAST  = SELW'(NCH - 1);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [SELW-1:0]  ptr;

  logic             rr_found;
  logic [SELW-1:0]  rr_grant;

  logic [WIDTH-1:0] nxt_data;
  logic             nxt_valid;
  logic [SELW-1:0]  nxt_ch;
  logic [SELW-1:0]  nxt_ptr;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  // First valid channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NCH;
      if (!rr_found && in_valid[SELW'(idx)]) begin
        rr_found = 1'b1;
        rr_grant = SELW'(idx);
      end
    end
  end

  // Hold has priority over mode; anything not updated keeps its registered value.
  always_comb begin
    nxt_data  = out_data;
    nxt_ch    = out_ch;
    nxt_valid = 1'b0;
    nxt_ptr   = ptr;
    if (!hold) begin
      if (!mode) begin
        if ({1'b0, sel} < NCH_W) begin
          nxt_data  = ch_data[sel];
          nxt_ch    = sel;
          nxt_valid = in_valid[sel];
        end
      end else if (rr_found) begin
        nxt_data  = ch_data[rr_grant];
        nxt_ch    = rr_grant;
        nxt_valid = 1'b1;
        nxt_ptr   = (rr_grant == LAST) ? '0 : rr_grant + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample together.
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else begin
      out_data  <= nxt_data;
      out_valid <= nxt_valid;
      out_ch    <= nxt_ch;
      ptr       <= nxt_ptr;
      if (nxt_valid) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_mux_n.sv
// Scoreboard bench for reg_mux_n: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares them against the outputs.
module tb_reg_mux_n;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ch;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        hold;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] xfer_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  localparam logic [63:0] D_HEX = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
  localparam logic [63:0] D_HLD = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
  localparam logic [63:0] D_A   = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
  localparam logic [63:0] D_X   = {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC};

  reg_mux_n #(.WIDTH(16), .NCH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .hold      (hold),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per edge, sampled 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("out_data",  32'(out_data),  32'(e.data));
      check("out_ch",    32'(out_ch),    32'(e.ch));
      check("out_valid", 32'(out_valid), 32'(e.valid));
      check("xfer_cnt",  32'(xfer_cnt),  32'(e.cnt));
    end
  end

  // Called at a negedge: drive inputs, queue the result for the next edge, advance.
  task automatic step(input logic m, input logic [1:0] s, input logic [63:0] d,
                      input logic [3:0] v, input logic h,
                      input logic [15:0] ed, input logic [1:0] ec,
                      input logic ev, input logic [15:0] ecnt);
    exp_t e;
    mode     = m;
    sel      = s;
    in_data  = d;
    in_valid = v;
    hold     = h;
    e.data   = ed;
    e.ch     = ec;
    e.valid  = ev;
    e.cnt    = ecnt;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  32'(out_data),  32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_ch"},    32'(out_ch),    32'h0);
    check({tag, "_cnt"},   32'(xfer_cnt),  32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    mode     = 1'b0;
    sel      = 2'd0;
    in_data  = D_HEX;
    in_valid = 4'hF;
    hold     = 1'b1;
    #3;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_edge");
    rst_n = 1'b1;

    // Direct select, all valid
    step(0, 2'd0, D_HEX, 4'hF, 0, 16'h0001, 2'd0, 1, 16'd1);
    step(0, 2'd1, D_HEX, 4'hF, 0, 16'h0010, 2'd1, 1, 16'd2);
    step(0, 2'd0, D_HEX, 4'hF, 0, 16'h0001, 2'd0, 1, 16'd3);
    // Selected channel not valid: data and channel still update
    step(0, 2'd2, D_HEX, 4'b1011, 0, 16'h0100, 2'd2, 0, 16'd3);
    // Hold for three cycles while sel and data move
    step(0, 2'd3, D_HLD, 4'hF, 1, 16'h0100, 2'd2, 0, 16'd3);
    step(0, 2'd1, D_X,   4'hF, 1, 16'h0100, 2'd2, 0, 16'd3);
    step(0, 2'd0, D_A,   4'hF, 1, 16'h0100, 2'd2, 0, 16'd3);
    step(0, 2'd3, D_HEX, 4'hF, 0, 16'h1000, 2'd3, 1, 16'd4);

    // Round-robin, all valid, ptr starts at 0
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A0, 2'd0, 1, 16'd5);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A1, 2'd1, 1, 16'd6);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A2, 2'd2, 1, 16'd7);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A3, 2'd3, 1, 16'd8);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A0, 2'd0, 1, 16'd9);
    // Round-robin over channels 1 and 3 (ptr starts at 1)
    step(1, 2'd0, D_A, 4'b1010, 0, 16'h00A1, 2'd1, 1, 16'd10);
    step(1, 2'd0, D_A, 4'b1010, 0, 16'h00A3, 2'd3, 1, 16'd11);
    step(1, 2'd0, D_A, 4'b1010, 0, 16'h00A1, 2'd1, 1, 16'd12);
    step(1, 2'd0, D_A, 4'b1010, 0, 16'h00A3, 2'd3, 1, 16'd13);
    // Nothing valid: outputs hold, non-granted data ignored
    step(1, 2'd0, D_X, 4'b0000, 0, 16'h00A3, 2'd3, 0, 16'd13);
    step(1, 2'd0, D_X, 4'b0000, 0, 16'h00A3, 2'd3, 0, 16'd13);
    // ptr stayed at 0
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A0, 2'd0, 1, 16'd14);
    // Mode switches with no idle cycle; ptr (1) kept across direct mode
    step(0, 2'd3, D_A, 4'hF, 0, 16'h00A3, 2'd3, 1, 16'd15);
    step(1, 2'd3, D_A, 4'hF, 0, 16'h00A1, 2'd1, 1, 16'd16);
    // Wrap search: ptr=2, only channel 0 valid
    step(1, 2'd0, D_A, 4'b0001, 0, 16'h00A0, 2'd0, 1, 16'd17);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A1, 2'd1, 1, 16'd18);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A2, 2'd2, 1, 16'd19);

    // Reset between edges during streaming
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_held");
    rst_n = 1'b1;
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A0, 2'd0, 1, 16'd1);
    step(1, 2'd0, D_A, 4'hF, 0, 16'h00A1, 2'd1, 1, 16'd2);

    // Stream up to 16'hFFFE, then two more transfers wrap the counter
    for (int k = 3; k <= 32'hFFFE; k++) begin
      step(0, 2'd0, D_A, 4'hF, 0, 16'h00A0, 2'd0, 1, 16'(k));
    end
    step(0, 2'd1, D_A, 4'hF, 0, 16'h00A1, 2'd1, 1, 16'hFFFF);
    step(0, 2'd2, D_A, 4'hF, 0, 16'h00A2, 2'd2, 1, 16'h0000);
    step(0, 2'd3, D_A, 4'hF, 1, 16'h00A2, 2'd2, 0, 16'h0000);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_mux_n.md
REG_MUX_N -- requirements
Module: reg_mux_n

Interface
REQ-001 Parameter WIDTH, default 16: data width of every channel, in bits.
REQ-002 Parameter NCH, default 4: number of input channels; legal range 2..8.
REQ-003 Parameter SELW, default 2: select and channel-index width; SHALL equal ceil(log2(NCH)).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port mode, input, 1: 0 = direct select, 1 = round-robin scan.
REQ-007 Port sel, input, SELW: channel select, used in direct mode only.
REQ-008 Port in_data, input, NCH*WIDTH: packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_valid, input, NCH: per-channel data-valid flags.
REQ-010 Port hold, input, 1: freeze request.
REQ-011 Port out_data, output, WIDTH: registered selected data.
REQ-012 Port out_valid, output, 1: registered; high when out_data carries a new transfer this cycle.
REQ-013 Port out_ch, output, SELW: registered index of the channel that produced out_data.
REQ-014 Port xfer_cnt, output, 16: count of completed transfers.

Function
REQ-015 All outputs SHALL be registered, with a latency of exactly one clk edge from the sampled inputs.
REQ-016 Evaluation priority SHALL be: hold first, then mode.
REQ-017 When hold=1, out_data, out_ch, xfer_cnt and the scan pointer ptr SHALL keep their values, and out_valid SHALL be driven to 0.
REQ-018 Direct mode with sel<NCH: out_data <= channel sel; out_ch <= sel; out_valid <= in_valid[sel].
REQ-019 Direct mode with sel>=NCH: out_valid <= 0, and out_data and out_ch SHALL hold their values.
REQ-020 Direct mode with in_valid[sel]=0: out_data and out_ch SHALL still update, and out_valid SHALL be 0.
REQ-021 Round-robin mode: the block SHALL grant the first channel g with in_valid[g]=1, searching ptr, ptr+1, ... and wrapping modulo NCH.
REQ-022 Round-robin grant: out_data <= channel g; out_ch <= g; out_valid <= 1; ptr <= (g+1) mod NCH.
REQ-023 Round-robin with no valid channel: out_valid <= 0, and out_data, out_ch and ptr SHALL hold their values.
REQ-024 ptr SHALL update only on a round-robin grant; it SHALL keep its value in direct mode and across mode changes.
REQ-025 A mode change SHALL take effect at the first edge that samples the new value, with no idle cycle inserted.
REQ-026 xfer_cnt SHALL increment by 1 on every edge at which out_valid is registered as 1.
REQ-027 xfer_cnt SHALL wrap from 16'hFFFF to 0 with no saturation and no flag.
REQ-028 in_valid and in_data on channels that are not granted SHALL have no effect on any output.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously set out_data=0, out_valid=0, out_ch=0, xfer_cnt=0 and ptr=0.
REQ-030 Reset asserted mid-operation SHALL abort the current transfer; no partial update SHALL remain after the next edge.
REQ-031 After release of rst_n, the first update SHALL occur on the first rising clk edge at which rst_n=1.

Verification
REQ-032 Direct mode, NCH=4, WIDTH=16, ch0=16'h0001, ch1=16'h0010, all in_valid=1:
  - sel toggles 0,1,0 -> out_data sequence 0001, 0010, 0001, each one edge later;
  - out_ch = 0,1,0; out_valid=1; xfer_cnt=1,2,3.
REQ-033 Round-robin, in_valid=4'b1111, channels 16'hA0..A3, from reset:
  - grants ch0,1,2,3,0 on consecutive edges;
  - out_ch = 0,1,2,3,0.
REQ-034 Round-robin with in_valid=4'b1010:
  - grants ch1,3,1,3;
  - when in_valid drops to 0, out_valid=0, out_data holds the last A3 value, and ptr stays at 0.
REQ-035 Direct mode with hold=1 for 3 cycles while sel and data change:
  - out_valid=0 and out_data unchanged throughout;
  - xfer_cnt frozen;
  - normal update on the first edge after hold=0.
REQ-036 Preload xfer_cnt to 16'hFFFE via streaming, then 2 valid transfers -> xfer_cnt = 16'hFFFF, then 16'h0000.
REQ-037 Assert rst_n=0 between edges during round-robin streaming:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release, the first grant is ch0 (ptr=0).
